// File: rtl/gfx_setup_pkg.sv
// Shared constants for the triangle setup stage: default widths,
// FSM state encoding and the doubled-area width helper.
package gfx_setup_pkg;

    localparam int POINT_WIDTH    = 16;
    localparam int SUBPIXEL_WIDTH = 16;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_BBOX   = 3'd1;
    localparam state_t ST_MUL_A  = 3'd2;
    localparam state_t ST_MUL_B  = 3'd3;
    localparam state_t ST_DECIDE = 3'd4;
    localparam state_t ST_OUT    = 3'd5;

    // Each difference is point_width+1 bits, so one product needs
    // 2*point_width+2 bits and the difference of two products needs one more.
    function automatic int area_width(input int pw);
        return 2 * pw + 3;
    endfunction

endpackage

// File: rtl/gfx_triangle_setup_if.sv
// Setup-to-rasterizer result bundle with valid/ready handshake.
// master: setup stage (drives results), slave: rasterizer (drives ready).
// zmin/zmax exist only when GFX_TRIANGLE_SETUP_ZRANGE_EN is defined.
interface gfx_triangle_setup_if
    import gfx_setup_pkg::*;
#(
    parameter int point_width = POINT_WIDTH
);

    localparam int AreaW = area_width(point_width);

    logic                          rast_valid;
    logic                          rast_ready;
    logic        [point_width-1:0] bbox_x0;
    logic        [point_width-1:0] bbox_y0;
    logic        [point_width-1:0] bbox_x1;
    logic        [point_width-1:0] bbox_y1;
    logic signed [AreaW-1:0]       area;

`ifdef GFX_TRIANGLE_SETUP_ZRANGE_EN
    logic signed [point_width-1:0] zmin;
    logic signed [point_width-1:0] zmax;

    modport master (
        output rast_valid, bbox_x0, bbox_y0, bbox_x1, bbox_y1, area,
        output zmin, zmax,
        input  rast_ready
    );

    modport slave (
        input  rast_valid, bbox_x0, bbox_y0, bbox_x1, bbox_y1, area,
        input  zmin, zmax,
        output rast_ready
    );
`else
    modport master (
        output rast_valid, bbox_x0, bbox_y0, bbox_x1, bbox_y1, area,
        input  rast_ready
    );

    modport slave (
        input  rast_valid, bbox_x0, bbox_y0, bbox_x1, bbox_y1, area,
        output rast_ready
    );
`endif

endinterface

// File: rtl/gfx_minmax3.sv
// Combinational signed minimum and maximum of three values.
// Ports: a_i/b_i/c_i operands, min_o/max_o results.
module gfx_minmax3 #(
    parameter int width = 16
) (
    input  logic signed [width-1:0] a_i,
    input  logic signed [width-1:0] b_i,
    input  logic signed [width-1:0] c_i,
    output logic signed [width-1:0] min_o,
    output logic signed [width-1:0] max_o
);

    logic signed [width-1:0] ab_min;
    logic signed [width-1:0] ab_max;

    always_comb begin
        ab_min = (a_i < b_i) ? a_i : b_i;
        ab_max = (a_i > b_i) ? a_i : b_i;
        min_o  = (c_i < ab_min) ? c_i : ab_min;
        max_o  = (c_i > ab_max) ? c_i : ab_max;
    end

endmodule

// File: rtl/gfx_triangle_setup.sv
// Triangle setup: clipped integer bounding box, doubled signed area and
// back-face / degenerate / off-screen culling, results to the rasterizer.
// Ports: clk_i, rst_i (async, active high); p{0,1,2}_{x,y}_i fixed-point
// vertices, p{0,1,2}_z_i depth; clip_{x0,y0,x1,y1}_i inclusive clip rect;
// cull_en_i back-face enable; start_i request; ack_o/culled_o retire pulse;
// rast result bundle (gfx_triangle_setup_if.master).
// Optional macro GFX_TRIANGLE_SETUP_ZRANGE_EN adds the z range outputs.
module gfx_triangle_setup
    import gfx_setup_pkg::*;
#(
    parameter int point_width    = POINT_WIDTH,
    parameter int subpixel_width = SUBPIXEL_WIDTH
) (
    input  logic                                         clk_i,
    input  logic                                         rst_i,
    input  logic signed [point_width+subpixel_width-1:0] p0_x_i,
    input  logic signed [point_width+subpixel_width-1:0] p0_y_i,
    input  logic signed [point_width+subpixel_width-1:0] p1_x_i,
    input  logic signed [point_width+subpixel_width-1:0] p1_y_i,
    input  logic signed [point_width+subpixel_width-1:0] p2_x_i,
    input  logic signed [point_width+subpixel_width-1:0] p2_y_i,
    input  logic signed [point_width-1:0]                p0_z_i,
    input  logic signed [point_width-1:0]                p1_z_i,
    input  logic signed [point_width-1:0]                p2_z_i,
    input  logic        [point_width-1:0]                clip_x0_i,
    input  logic        [point_width-1:0]                clip_y0_i,
    input  logic        [point_width-1:0]                clip_x1_i,
    input  logic        [point_width-1:0]                clip_y1_i,
    input  logic                                         cull_en_i,
    input  logic                                         start_i,
    output logic                                         ack_o,
    output logic                                         culled_o,
    gfx_triangle_setup_if.master                         rast
);

    localparam int PW = point_width;
    localparam int SW = subpixel_width;
    localparam int DW = PW + 1;
    localparam int MW = 2 * DW;
    localparam int AW = area_width(PW);

    state_t state_q;
    state_t state_d;

    logic signed [PW-1:0] x0_q, y0_q, x1_q, y1_q, x2_q, y2_q;
    logic        [PW-1:0] cx0_q, cy0_q, cx1_q, cy1_q;
    logic                 cull_en_q;

    logic signed [PW-1:0] min_x_c, max_x_c, min_y_c, max_y_c;
    logic signed [PW-1:0] min_x_q, max_x_q, min_y_q, max_y_q;

    logic signed [DW-1:0] dx1_c, dy1_c, dx2_c, dy2_c;
    logic signed [DW-1:0] dx1_q, dy1_q, dx2_q, dy2_q;

    logic signed [DW-1:0] mul_l, mul_r;
    logic signed [MW-1:0] prod_c;
    logic signed [MW-1:0] prod_a_q;
    logic signed [AW-1:0] area_c;
    logic signed [AW-1:0] area_q;

    logic signed [DW-1:0] min_xe, max_xe, min_ye, max_ye;
    logic signed [DW-1:0] cx0e, cy0e, cx1e, cy1e;
    logic                 off_c;
    logic                 cull_c;
    logic        [PW-1:0] bx0_c, by0_c, bx1_c, by1_c;

    logic ld_in, ld_box, ld_a, ld_area, ld_res;
    logic ack_set, culled_set, hs_done;

    // Setup only uses the integer field of each 16.16 coordinate.
    logic unused_frac;
    assign unused_frac = ^{p0_x_i[SW-1:0], p0_y_i[SW-1:0],
                           p1_x_i[SW-1:0], p1_y_i[SW-1:0],
                           p2_x_i[SW-1:0], p2_y_i[SW-1:0]};

    gfx_minmax3 #(.width(PW)) u_mm_x (
        .a_i   (x0_q),
        .b_i   (x1_q),
        .c_i   (x2_q),
        .min_o (min_x_c),
        .max_o (max_x_c)
    );

    gfx_minmax3 #(.width(PW)) u_mm_y (
        .a_i   (y0_q),
        .b_i   (y1_q),
        .c_i   (y2_q),
        .min_o (min_y_c),
        .max_o (max_y_c)
    );

    always_comb begin
        dx1_c = DW'(x1_q) - DW'(x0_q);
        dy1_c = DW'(y1_q) - DW'(y0_q);
        dx2_c = DW'(x2_q) - DW'(x0_q);
        dy2_c = DW'(y2_q) - DW'(y0_q);
    end

    // One shared multiplier: MUL_A forms dx1*dy2, MUL_B forms dx2*dy1.
    always_comb begin
        mul_l  = (state_q == ST_MUL_A) ? dx1_q : dx2_q;
        mul_r  = (state_q == ST_MUL_A) ? dy2_q : dy1_q;
        prod_c = MW'(mul_l) * MW'(mul_r);
        area_c = AW'(prod_a_q) - AW'(prod_c);
    end

    // Box is signed, clip is unsigned: compare both one bit wider.
    always_comb begin
        min_xe = {min_x_q[PW-1], min_x_q};
        max_xe = {max_x_q[PW-1], max_x_q};
        min_ye = {min_y_q[PW-1], min_y_q};
        max_ye = {max_y_q[PW-1], max_y_q};
        cx0e   = {1'b0, cx0_q};
        cy0e   = {1'b0, cy0_q};
        cx1e   = {1'b0, cx1_q};
        cy1e   = {1'b0, cy1_q};
        off_c  = (max_xe < cx0e) || (min_xe > cx1e) ||
                 (max_ye < cy0e) || (min_ye > cy1e);
        cull_c = (area_q == '0) || (cull_en_q && area_q[AW-1]) || off_c;
        // Not culled implies each clamped edge is non-negative.
        bx0_c  = (min_xe > cx0e) ? min_x_q : cx0_q;
        by0_c  = (min_ye > cy0e) ? min_y_q : cy0_q;
        bx1_c  = (max_xe < cx1e) ? max_x_q : cx1_q;
        by1_c  = (max_ye < cy1e) ? max_y_q : cy1_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   state_d = start_i ? ST_BBOX : ST_IDLE;
            ST_BBOX:   state_d = ST_MUL_A;
            ST_MUL_A:  state_d = ST_MUL_B;
            ST_MUL_B:  state_d = ST_DECIDE;
            ST_DECIDE: state_d = cull_c ? ST_IDLE : ST_OUT;
            ST_OUT:    state_d = rast.rast_ready ? ST_IDLE : ST_OUT;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ld_in      = (state_q == ST_IDLE) && start_i;
        ld_box     = (state_q == ST_BBOX);
        ld_a       = (state_q == ST_MUL_A);
        ld_area    = (state_q == ST_MUL_B);
        ld_res     = (state_q == ST_DECIDE) && !cull_c;
        culled_set = (state_q == ST_DECIDE) && cull_c;
        hs_done    = (state_q == ST_OUT) && rast.rast_ready;
        ack_set    = culled_set || hs_done;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            x0_q      <= '0;
            y0_q      <= '0;
            x1_q      <= '0;
            y1_q      <= '0;
            x2_q      <= '0;
            y2_q      <= '0;
            cx0_q     <= '0;
            cy0_q     <= '0;
            cx1_q     <= '0;
            cy1_q     <= '0;
            cull_en_q <= 1'b0;
            min_x_q   <= '0;
            max_x_q   <= '0;
            min_y_q   <= '0;
            max_y_q   <= '0;
            dx1_q     <= '0;
            dy1_q     <= '0;
            dx2_q     <= '0;
            dy2_q     <= '0;
            prod_a_q  <= '0;
            area_q    <= '0;
        end else begin
            if (ld_in) begin
                x0_q      <= p0_x_i[SW +: PW];
                y0_q      <= p0_y_i[SW +: PW];
                x1_q      <= p1_x_i[SW +: PW];
                y1_q      <= p1_y_i[SW +: PW];
                x2_q      <= p2_x_i[SW +: PW];
                y2_q      <= p2_y_i[SW +: PW];
                cx0_q     <= clip_x0_i;
                cy0_q     <= clip_y0_i;
                cx1_q     <= clip_x1_i;
                cy1_q     <= clip_y1_i;
                cull_en_q <= cull_en_i;
            end
            if (ld_box) begin
                min_x_q <= min_x_c;
                max_x_q <= max_x_c;
                min_y_q <= min_y_c;
                max_y_q <= max_y_c;
                dx1_q   <= dx1_c;
                dy1_q   <= dy1_c;
                dx2_q   <= dx2_c;
                dy2_q   <= dy2_c;
            end
            if (ld_a) begin
                prod_a_q <= prod_c;
            end
            if (ld_area) begin
                area_q <= area_c;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack_o           <= 1'b0;
            culled_o        <= 1'b0;
            rast.rast_valid <= 1'b0;
            rast.bbox_x0    <= '0;
            rast.bbox_y0    <= '0;
            rast.bbox_x1    <= '0;
            rast.bbox_y1    <= '0;
            rast.area       <= '0;
        end else begin
            ack_o    <= ack_set;
            culled_o <= culled_set;
            if (ld_res) begin
                rast.rast_valid <= 1'b1;
                rast.bbox_x0    <= bx0_c;
                rast.bbox_y0    <= by0_c;
                rast.bbox_x1    <= bx1_c;
                rast.bbox_y1    <= by1_c;
                rast.area       <= area_q;
            end else if (hs_done) begin
                rast.rast_valid <= 1'b0;
            end
        end
    end

`ifdef GFX_TRIANGLE_SETUP_ZRANGE_EN
    logic signed [PW-1:0] z0_q, z1_q, z2_q;
    logic signed [PW-1:0] min_z_c, max_z_c;
    logic signed [PW-1:0] min_z_q, max_z_q;

    gfx_minmax3 #(.width(PW)) u_mm_z (
        .a_i   (z0_q),
        .b_i   (z1_q),
        .c_i   (z2_q),
        .min_o (min_z_c),
        .max_o (max_z_c)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            z0_q      <= '0;
            z1_q      <= '0;
            z2_q      <= '0;
            min_z_q   <= '0;
            max_z_q   <= '0;
            rast.zmin <= '0;
            rast.zmax <= '0;
        end else begin
            if (ld_in) begin
                z0_q <= p0_z_i;
                z1_q <= p1_z_i;
                z2_q <= p2_z_i;
            end
            if (ld_box) begin
                min_z_q <= min_z_c;
                max_z_q <= max_z_c;
            end
            if (ld_res) begin
                rast.zmin <= min_z_q;
                rast.zmax <= max_z_q;
            end
        end
    end
`else
    logic unused_z;
    assign unused_z = ^{p0_z_i, p1_z_i, p2_z_i};
`endif

endmodule

// File: tb/tb_gfx_triangle_setup.sv
// Self-checking bench for gfx_triangle_setup: directed table plus
// randomized triangles checked against an arithmetic reference model.
module tb_gfx_triangle_setup;

    logic               clk_i = 1'b0;
    logic               rst_i = 1'b1;
    logic signed [31:0] p0_x_i, p0_y_i, p1_x_i, p1_y_i, p2_x_i, p2_y_i;
    logic signed [15:0] p0_z_i, p1_z_i, p2_z_i;
    logic        [15:0] clip_x0_i, clip_y0_i, clip_x1_i, clip_y1_i;
    logic               cull_en_i;
    logic               start_i;
    logic               ack_o;
    logic               culled_o;

    int n_pass  = 0;
    int n_total = 0;

    gfx_triangle_setup_if rast ();

    gfx_triangle_setup dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .p0_x_i    (p0_x_i),
        .p0_y_i    (p0_y_i),
        .p1_x_i    (p1_x_i),
        .p1_y_i    (p1_y_i),
        .p2_x_i    (p2_x_i),
        .p2_y_i    (p2_y_i),
        .p0_z_i    (p0_z_i),
        .p1_z_i    (p1_z_i),
        .p2_z_i    (p2_z_i),
        .clip_x0_i (clip_x0_i),
        .clip_y0_i (clip_y0_i),
        .clip_x1_i (clip_x1_i),
        .clip_y1_i (clip_y1_i),
        .cull_en_i (cull_en_i),
        .start_i   (start_i),
        .ack_o     (ack_o),
        .culled_o  (culled_o),
        .rast      (rast)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int     x0, y0, x1, y1, x2, y2;
        int     cx0, cy0, cx1, cy1;
        bit     cull;
        int     hold;
        bit     e_cull;
        int     e_bx0, e_by0, e_bx1, e_by1;
        longint e_area;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Reference: plain-integer geometry on the triangle's integer vertices.
    function automatic vec_t model(input vec_t v);
        int mnx, mxx, mny, mxy;
        longint a;
        mnx = imin(v.x0, imin(v.x1, v.x2));
        mxx = imax(v.x0, imax(v.x1, v.x2));
        mny = imin(v.y0, imin(v.y1, v.y2));
        mxy = imax(v.y0, imax(v.y1, v.y2));
        a = longint'(v.x1 - v.x0) * longint'(v.y2 - v.y0)
          - longint'(v.x2 - v.x0) * longint'(v.y1 - v.y0);
        v.e_area = a;
        v.e_cull = (a == 0) || (v.cull && a < 0) ||
                   mxx < v.cx0 || mnx > v.cx1 ||
                   mxy < v.cy0 || mny > v.cy1;
        v.e_bx0 = imax(mnx, v.cx0);
        v.e_by0 = imax(mny, v.cy0);
        v.e_bx1 = imin(mxx, v.cx1);
        v.e_by1 = imin(mxy, v.cy1);
        return v;
    endfunction

    function automatic vec_t mk(input int x0, y0, x1, y1, x2, y2,
                                input int cx0, cy0, cx1, cy1,
                                input bit cull, input int hold,
                                input bit ec, input int b0, b1, b2, b3,
                                input longint ea);
        vec_t v;
        v.x0 = x0; v.y0 = y0; v.x1 = x1; v.y1 = y1; v.x2 = x2; v.y2 = y2;
        v.cx0 = cx0; v.cy0 = cy0; v.cx1 = cx1; v.cy1 = cy1;
        v.cull = cull; v.hold = hold; v.e_cull = ec;
        v.e_bx0 = b0; v.e_by0 = b1; v.e_bx1 = b2; v.e_by1 = b3;
        v.e_area = ea;
        return v;
    endfunction

    function automatic logic signed [31:0] fx(input int i);
        logic [15:0] fr;
        fr = 16'($urandom);
        return (i <<< 16) | int'({16'd0, fr});
    endfunction

    task automatic apply(input vec_t v);
        p0_x_i = fx(v.x0); p0_y_i = fx(v.y0);
        p1_x_i = fx(v.x1); p1_y_i = fx(v.y1);
        p2_x_i = fx(v.x2); p2_y_i = fx(v.y2);
        p0_z_i = 16'($urandom); p1_z_i = 16'($urandom); p2_z_i = 16'($urandom);
        clip_x0_i = 16'(v.cx0); clip_y0_i = 16'(v.cy0);
        clip_x1_i = 16'(v.cx1); clip_y1_i = 16'(v.cy1);
        cull_en_i = v.cull;
    endtask

    task automatic chk_res(input string tag, input vec_t v);
        chk({tag, "_bx0"}, longint'(rast.bbox_x0), v.e_bx0);
        chk({tag, "_by0"}, longint'(rast.bbox_y0), v.e_by0);
        chk({tag, "_bx1"}, longint'(rast.bbox_x1), v.e_bx1);
        chk({tag, "_by1"}, longint'(rast.bbox_y1), v.e_by1);
        chk({tag, "_area"}, longint'(rast.area), v.e_area);
    endtask

    task automatic run_tri(input vec_t v);
        @(posedge clk_i); #1;
        apply(v);
        rast.rast_ready = (v.hold == 0);
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk_i); #1;
            if (k < 4) begin
                chk("busy_ack", longint'(ack_o), 0);
                chk("busy_valid", longint'(rast.rast_valid), 0);
            end
        end
        if (v.e_cull) begin
            chk("cull_ack", longint'(ack_o), 1);
            chk("cull_flag", longint'(culled_o), 1);
            chk("cull_valid", longint'(rast.rast_valid), 0);
            @(posedge clk_i); #1;
            chk("cull_ack_drop", longint'(ack_o), 0);
        end else begin
            chk("res_valid", longint'(rast.rast_valid), 1);
            chk("res_ack", longint'(ack_o), 0);
            chk_res("res", v);
            for (int h = 0; h < v.hold; h++) begin
                start_i = h[0];
                p0_x_i  = fx(v.x0 + 7);
                @(posedge clk_i); #1;
                start_i = 1'b0;
                chk("hold_valid", longint'(rast.rast_valid), 1);
                chk("hold_ack", longint'(ack_o), 0);
                chk_res("hold", v);
            end
            rast.rast_ready = 1'b1;
            @(posedge clk_i); #1;
            rast.rast_ready = 1'b0;
            chk("hs_ack", longint'(ack_o), 1);
            chk("hs_culled", longint'(culled_o), 0);
            chk("hs_valid", longint'(rast.rast_valid), 0);
            chk_res("retain", v);
            if (v.hold > 0) begin
                for (int w = 0; w < 6; w++) begin
                    @(posedge clk_i); #1;
                    chk("post_ack", longint'(ack_o), 0);
                    chk("post_valid", longint'(rast.rast_valid), 0);
                end
            end
        end
    endtask

    initial begin
        vec_t v;
        start_i = 1'b0;
        rast.rast_ready = 1'b0;
        tbl.push_back(mk(10, 10, 20, 10, 10, 20, 0, 0, 639, 479, 0, 0,
                         0, 10, 10, 20, 20, 100));
        tbl.push_back(mk(10, 10, 10, 20, 20, 10, 0, 0, 639, 479, 1, 0,
                         1, 0, 0, 0, 0, -100));
        tbl.push_back(mk(10, 10, 10, 20, 20, 10, 0, 0, 639, 479, 0, 2,
                         0, 10, 10, 20, 20, -100));
        tbl.push_back(mk(0, 0, 5, 5, 10, 10, 0, 0, 639, 479, 0, 0,
                         1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 5, 5, 10, 10, 0, 0, 639, 479, 1, 0,
                         1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(-50, -20, 700, 30, 100, 600, 0, 0, 639, 479, 0, 0,
                         0, 0, 0, 639, 479, 457500));
        tbl.push_back(mk(10, 10, 20, 10, 10, 20, 500, 0, 100, 479, 0, 0,
                         1, 0, 0, 0, 0, 100));
        tbl.push_back(mk(700, 10, 720, 10, 700, 30, 0, 0, 639, 479, 0, 0,
                         1, 0, 0, 0, 0, 400));
        tbl.push_back(mk(10, 10, 20, 10, 10, 20, 0, 0, 639, 479, 0, 10,
                         0, 10, 10, 20, 20, 100));

        apply(tbl[0]);
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_valid", longint'(rast.rast_valid), 0);
        chk("rst_ack", longint'(ack_o), 0);
        chk("rst_culled", longint'(culled_o), 0);
        chk("rst_area", longint'(rast.area), 0);
        chk("rst_bx1", longint'(rast.bbox_x1), 0);
        rst_i = 1'b0;

        for (int i = 0; i < tbl.size(); i++) run_tri(tbl[i]);

        // Reset in MUL_B aborts the triangle without any ack.
        @(posedge clk_i); #1;
        apply(tbl[5]);
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        #1;
        chk("abort_valid", longint'(rast.rast_valid), 0);
        chk("abort_ack", longint'(ack_o), 0);
        chk("abort_area", longint'(rast.area), 0);
        chk("abort_bx0", longint'(rast.bbox_x0), 0);
        chk("abort_by1", longint'(rast.bbox_y1), 0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        for (int w = 0; w < 6; w++) begin
            @(posedge clk_i); #1;
            chk("abort_no_ack", longint'(ack_o), 0);
            chk("abort_no_valid", longint'(rast.rast_valid), 0);
        end
        run_tri(tbl[0]);

        for (int r = 0; r < 60; r++) begin
            v.x0 = int'($urandom_range(1100)) - 200;
            v.y0 = int'($urandom_range(1100)) - 200;
            v.x1 = int'($urandom_range(1100)) - 200;
            v.y1 = int'($urandom_range(1100)) - 200;
            v.x2 = int'($urandom_range(1100)) - 200;
            v.y2 = int'($urandom_range(1100)) - 200;
            if ($urandom_range(7) == 0) begin
                v.x2 = v.x0;
                v.y2 = v.y0;
            end
            v.cx0  = int'($urandom_range(300));
            v.cy0  = int'($urandom_range(300));
            v.cx1  = int'($urandom_range(700, 100));
            v.cy1  = int'($urandom_range(700, 100));
            v.cull = 1'($urandom_range(1));
            v.hold = int'($urandom_range(3));
            run_tri(model(v));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
